npu_result_drain: RTL and testbench

Downstream stage of the NPU memory-mapped PE array: captures the N parallel PE accumulator results in one cycle, requantizes each to a signed 8-bit activation (optional ReLU, rounding right shift, saturation), and drains them as packed 32-bit words over a valid/ready stream toward the output buffer/DMA. It decouples the PE array from the write-back path: the array can start its next reduction as soon as a snapshot is taken.

---
 rtl/npu_pkg.sv | 19 +
 rtl/pe_requant.sv | 38 +++
 rtl/npu_result_drain.sv | 124 ++++++++++++
 tb/tb_npu_result_drain.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU result drain path.
// State encoding is kept as plain constants so older tooling can consume it.
package npu_pkg;

  typedef logic [0:0] drain_state_t;

  localparam drain_state_t IDLE  = 1'b0;
  localparam drain_state_t DRAIN = 1'b1;

  localparam int LANES = 4;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  function automatic int words_per_cap(input int n);
    return (n + LANES - 1) / LANES;
  endfunction

endpackage

// File: rtl/pe_requant.sv
// One-lane requantizer: optional ReLU, round-half-up arithmetic right shift,
// then saturation to a signed activation. Purely combinational.
module pe_requant
  import npu_pkg::*;
#(
  parameter int W_ACC      = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [W_ACC-1:0]      x,
  input  logic        [4:0]            shift,
  input  logic                         relu,
  output logic        [DATA_WIDTH-1:0] y
);

  localparam logic [4:0]             MAX_SHIFT = 5'(W_ACC - 1);
  localparam logic signed [W_ACC:0]  HI        = (W_ACC + 1)'(SAT_MAX);
  localparam logic signed [W_ACC:0]  LO        = (W_ACC + 1)'(SAT_MIN);

  logic        [4:0]   sh;
  logic signed [W_ACC:0] wide;
  logic signed [W_ACC:0] bias;
  logic signed [W_ACC:0] shifted;

  // One extra bit of headroom keeps x + bias from wrapping near the positive limit.
  always_comb begin
    sh      = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
    wide    = {x[W_ACC-1], x};
    bias    = '0;
    if (sh != 5'd0) bias = (W_ACC + 1)'(1) << (sh - 5'd1);
    shifted = (wide + bias) >>> sh;

    if (relu && x[W_ACC-1])  y = '0;
    else if (shifted > HI)   y = HI[DATA_WIDTH-1:0];
    else if (shifted < LO)   y = LO[DATA_WIDTH-1:0];
    else                     y = shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/npu_result_drain.sv
// Snapshots the PE accumulator results in one cycle and drains them as packed,
// requantized stream words so the PE array can start its next reduction at once.
module npu_result_drain
  import npu_pkg::*;
#(
  parameter int N          = 10,
  parameter int W_ACC      = 24,
  parameter int DATA_WIDTH = 8,
  parameter int AXI_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cap_i,
  input  logic [N*W_ACC-1:0]     results_i,
  input  logic [4:0]             shift_i,
  input  logic                   relu_en_i,
  input  logic                   clr_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [AXI_WIDTH-1:0]   m_data_o,
  output logic                   m_last_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int LANES_P  = AXI_WIDTH / DATA_WIDTH;
  localparam int WORDS    = words_per_cap(N);
  localparam int CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PAD_BITS = WORDS * LANES_P * W_ACC;

  drain_state_t         state;
  logic [CW-1:0]        word_cnt;
  logic [N*W_ACC-1:0]   snap;
  logic [4:0]           snap_shift;
  logic                 snap_relu;
  logic                 overflow;

  logic                 handshake;
  logic                 last_word;
  logic                 restart;
  logic [PAD_BITS-1:0]  snap_pad;
  logic [AXI_WIDTH-1:0] packed_word;

  assign handshake = m_valid_o & m_ready_i;
  assign last_word = (word_cnt == CW'(WORDS - 1));
  assign restart   = handshake & last_word & cap_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      snap       <= '0;
      snap_shift <= '0;
      snap_relu  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cap_i) begin
            snap       <= results_i;
            snap_shift <= shift_i;
            snap_relu  <= relu_en_i;
            word_cnt   <= '0;
            state      <= DRAIN;
          end
        end
        default: begin
          if (handshake) begin
            if (last_word) begin
              word_cnt <= '0;
              // A capture landing on the final handshake chains straight into a new drain.
              if (cap_i) begin
                snap       <= results_i;
                snap_shift <= shift_i;
                snap_relu  <= relu_en_i;
              end else begin
                state <= IDLE;
              end
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                overflow <= 1'b0;
    else if (state == DRAIN && cap_i && !restart) overflow <= 1'b1;
    else if (clr_i)                              overflow <= 1'b0;
  end

  always_comb begin
    snap_pad                = '0;
    snap_pad[N*W_ACC-1:0]   = snap;
  end

  // Lanes past N read the zero padding, which requantizes to 0x00.
  for (genvar k = 0; k < LANES_P; k++) begin : g_lane
    logic [W_ACC-1:0]      lane_x;
    logic [DATA_WIDTH-1:0] lane_y;

    always_comb lane_x = snap_pad[(int'(word_cnt) * LANES_P + k) * W_ACC +: W_ACC];

    pe_requant #(
      .W_ACC      (W_ACC),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_requant (
      .x     (lane_x),
      .shift (snap_shift),
      .relu  (snap_relu),
      .y     (lane_y)
    );

    assign packed_word[k*DATA_WIDTH +: DATA_WIDTH] = lane_y;
  end

  assign m_valid_o  = (state == DRAIN);
  assign busy_o     = (state == DRAIN);
  assign m_last_o   = m_valid_o & last_word;
  assign m_data_o   = m_valid_o ? packed_word : '0;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_npu_result_drain.sv
// Directed and randomized bench for npu_result_drain with a lane-level
// requantization model and word packing computed from plain arithmetic.
module tb_npu_result_drain;

  localparam int N     = 10;
  localparam int W_ACC = 24;
  localparam int WORDS = 3;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               cap_i;
  logic [N*W_ACC-1:0] results_i;
  logic [4:0]         shift_i;
  logic               relu_en_i;
  logic               clr_i;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [31:0]        m_data_o;
  logic               m_last_o;
  logic               busy_o;
  logic               overflow_o;

  int          tests = 0;
  int          fails = 0;
  longint      lanes [N];
  logic [31:0] exp_words [WORDS];

  always #5 clk = ~clk;

  npu_result_drain #(
    .N          (N),
    .W_ACC      (W_ACC),
    .DATA_WIDTH (8),
    .AXI_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cap_i      (cap_i),
    .results_i  (results_i),
    .shift_i    (shift_i),
    .relu_en_i  (relu_en_i),
    .clr_i      (clr_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] ref_requant(input longint x, input int sh_in, input bit relu);
    longint y;
    int     sh;
    sh = (sh_in > W_ACC - 1) ? W_ACC - 1 : sh_in;
    if (relu && x < 0) return 8'h00;
    y = x + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
    y = y >>> sh;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction

  function automatic void build_expected(input int sh, input bit relu);
    for (int w = 0; w < WORDS; w++) begin
      exp_words[w] = '0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < N)
          exp_words[w][8*k +: 8] = ref_requant(lanes[w * 4 + k], sh, relu);
    end
  endfunction

  // Called on a falling edge; leaves the bench on the falling edge after the capture edge.
  task automatic apply_stimulus(input int sh, input bit relu);
    for (int i = 0; i < N; i++) results_i[i*W_ACC +: W_ACC] = lanes[i][W_ACC-1:0];
    shift_i   = 5'(sh);
    relu_en_i = relu;
    build_expected(sh, relu);
    cap_i = 1'b1;
    @(negedge clk);
    cap_i = 1'b0;
  endtask

  task automatic drop_capture(input bit with_clr);
    for (int i = 0; i < N; i++) results_i[i*W_ACC +: W_ACC] = W_ACC'($urandom());
    shift_i = 5'($urandom_range(0, 31));
    cap_i   = 1'b1;
    clr_i   = with_clr;
    @(negedge clk);
    cap_i = 1'b0;
    clr_i = 1'b0;
  endtask

  task automatic expect_word(input string tag, input int w);
    check_output({tag, " valid"}, 32'(m_valid_o), 32'd1);
    check_output({tag, " data"},  m_data_o, exp_words[w]);
    check_output({tag, " last"},  32'(m_last_o), (w == WORDS - 1) ? 32'd1 : 32'd0);
  endtask

  task automatic drain_from(input string tag, input int first);
    for (int w = first; w < WORDS; w++) begin
      expect_word($sformatf("%s w%0d", tag, w), w);
      @(negedge clk);
    end
    check_output({tag, " busy after"},  32'(busy_o), 32'd0);
    check_output({tag, " valid after"}, 32'(m_valid_o), 32'd0);
  endtask

  task automatic random_lanes();
    logic [W_ACC-1:0] r;
    for (int i = 0; i < N; i++) begin
      r        = W_ACC'($urandom());
      lanes[i] = longint'($signed(r));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cap_i     = 1'b0;
    results_i = '0;
    shift_i   = '0;
    relu_en_i = 1'b0;
    clr_i     = 1'b0;
    m_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset valid",    32'(m_valid_o),  32'd0);
    check_output("reset last",     32'(m_last_o),   32'd0);
    check_output("reset data",     m_data_o,        32'd0);
    check_output("reset busy",     32'(busy_o),     32'd0);
    check_output("reset overflow", 32'(overflow_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Identity lanes, fixed expected words
    for (int i = 0; i < N; i++) lanes[i] = i;
    apply_stimulus(0, 1'b0);
    check_output("ident w0 const", m_data_o, 32'h03020100);
    @(negedge clk);
    check_output("ident w1 const", m_data_o, 32'h07060504);
    check_output("ident w1 last",  32'(m_last_o), 32'd0);
    @(negedge clk);
    check_output("ident w2 const", m_data_o, 32'h00000908);
    check_output("ident w2 last",  32'(m_last_o), 32'd1);
    @(negedge clk);
    check_output("ident busy after", 32'(busy_o), 32'd0);

    // Saturation, without and with ReLU
    random_lanes();
    lanes[0] = 64'sh7FFFFF;
    lanes[1] = -1000;
    apply_stimulus(0, 1'b0);
    check_output("sat bytes", 32'(m_data_o[15:0]), 32'h807F);
    drain_from("sat", 0);
    apply_stimulus(0, 1'b1);
    check_output("sat relu bytes", 32'(m_data_o[15:0]), 32'h007F);
    drain_from("sat relu", 0);

    // Rounding and oversized shift
    random_lanes();
    lanes[0] = 6;
    lanes[1] = -6;
    lanes[2] = 5;
    apply_stimulus(2, 1'b0);
    check_output("round bytes", 32'(m_data_o[23:0]), 32'h01FF02);
    drain_from("round", 0);
    lanes[0] = 64'sh400000;
    apply_stimulus(31, 1'b0);
    check_output("shift clamp byte", 32'(m_data_o[7:0]), 32'h01);
    drain_from("shift clamp", 0);

    // Randomized captures against the model
    for (int t = 0; t < 12; t++) begin
      random_lanes();
      apply_stimulus(int'($urandom_range(0, 31)), 1'($urandom()));
      drain_from($sformatf("rand%0d", t), 0);
    end

    // Backpressure on word 1
    random_lanes();
    apply_stimulus(int'($urandom_range(0, 12)), 1'b0);
    expect_word("bp w0", 0);
    @(negedge clk);
    m_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      expect_word($sformatf("bp hold%0d", c), 1);
      @(negedge clk);
    end
    m_ready_i = 1'b1;
    drain_from("bp release", 1);

    // Dropped capture during word 0, then clear
    random_lanes();
    apply_stimulus(3, 1'b0);
    expect_word("drop w0", 0);
    drop_capture(1'b0);
    check_output("drop overflow set", 32'(overflow_o), 32'd1);
    drain_from("drop", 1);
    check_output("drop overflow sticky", 32'(overflow_o), 32'd1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    check_output("clr overflow", 32'(overflow_o), 32'd0);

    // Capture coincident with the final handshake chains without overflow
    random_lanes();
    apply_stimulus(1, 1'b0);
    expect_word("chain a w0", 0);
    @(negedge clk);
    expect_word("chain a w1", 1);
    @(negedge clk);
    expect_word("chain a w2", 2);
    random_lanes();
    apply_stimulus(4, 1'b1);
    check_output("chain overflow", 32'(overflow_o), 32'd0);
    drain_from("chain b", 0);

    // Clear and dropped capture in the same cycle: set wins
    random_lanes();
    apply_stimulus(0, 1'b0);
    drop_capture(1'b1);
    check_output("clr vs drop", 32'(overflow_o), 32'd1);
    drain_from("clr vs drop", 1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;

    // Asynchronous reset mid-drain
    random_lanes();
    apply_stimulus(5, 1'b0);
    drop_capture(1'b0);
    check_output("pre-reset overflow", 32'(overflow_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_output("async valid",    32'(m_valid_o),  32'd0);
    check_output("async busy",     32'(busy_o),     32'd0);
    check_output("async overflow", 32'(overflow_o), 32'd0);
    check_output("async last",     32'(m_last_o),   32'd0);
    check_output("async data",     m_data_o,        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    random_lanes();
    apply_stimulus(2, 1'b1);
    drain_from("post reset", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
